ahblite_decode_mux: RTL and testbench
=====================================

# ahblite_decode_mux

Parametrised AHB-Lite decoder and slave-response multiplexer between the Cortex-M0 master and up to NPORT slaves. Address-phase decode uses per-port base/mask pairs. A registered data-phase select steers HREADYOUT/HRDATA/HRESP back to the master. An internal default slave returns the two-cycle AHB ERROR response for active transfers to unmapped addresses.

## Interface
Parameters:
- NPORT, 5, number of slave ports (1..16)
- PORT_EN, 5'b00111, per-port enable bit; a disabled port never decodes
- PORT_BASE, {32'h0, 32'h0, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000}, packed NPORT×32; port i occupies bits [32i+31:32i]
- PORT_MASK, {32'h0, 32'h0, 5{…}=32'hFFFF_0000 for ports 0..2}, packed NPORT×32; address bits compared for port i

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- HADDR  in  32  master address
- HTRANS  in  2  master transfer type
- HSEL  out  NPORT  address-phase select, one-hot or zero
- HREADYOUT_S  in  NPORT  per-slave ready
- HRESP_S  in  NPORT  per-slave response
- HRDATA_S  in  NPORT×32  per-slave read data, packed like PORT_BASE
- HREADY  out  1  muxed ready to master and all slaves
- HRESP  out  1  muxed response
- HRDATA  out  32  muxed read data

## Operation
- Hit: hit[i] = PORT_EN[i] && ((HADDR & PORT_MASK[i]) == (PORT_BASE[i] & PORT_MASK[i])).
- Overlap: lowest-index hit wins. HSEL is one-hot of the winner, zero if none. It is combinational from HADDR only, so slaves qualify it with HTRANS/HREADY.
- Miss = no hit. Active = HTRANS[1] (NONSEQ/SEQ).
- Data-phase register dsel (NPORT-bit one-hot, zero = default slave) loads the HSEL value when HREADY=1 and holds otherwise.
- Default-slave FSM states:
  - DS_IDLE → DS_ERR1 when HREADY=1 && active && miss.
  - DS_ERR1 → DS_ERR2, unconditional.
  - DS_ERR2 → DS_ERR1 if HREADY=1 && active && miss; otherwise → DS_IDLE.
- Default-slave outputs:
  - DS_IDLE: ready=1, resp=0.
  - DS_ERR1: ready=0, resp=1.
  - DS_ERR2: ready=1, resp=1.
  - IDLE/BUSY transfers to an unmapped address complete zero-wait with OKAY.
- Output mux:
  - dsel≠0: HREADY=HREADYOUT_S[k], HRESP=HRESP_S[k], HRDATA=HRDATA_S[k], where k = set bit.
  - dsel=0: default-slave ready/resp; HRDATA=32'h0.
- Slave ERROR responses pass through unchanged. The block adds no cycles to slave responses.

## Timing
- Reset (async assert, sync release): dsel=0, FSM=DS_IDLE, so HREADY=1, HRESP=0, HRDATA=0. HSEL follows HADDR immediately.
- Decode latency: 0 cycles (HSEL combinational). Response mux: 0 cycles after dsel; dsel updates one HCLK after the address phase.
- Wait states: while the selected slave holds HREADYOUT_S=0, dsel and FSM hold. The next address is not sampled.
- Back-to-back unmapped active transfers give the pattern ERR1, ERR2, ERR1, ERR2… with HREADY 0,1,0,1.
- Unmapped followed by mapped: dsel switches at the ERR2 edge and FSM returns to DS_IDLE.
- Reset asserted mid-ERROR: FSM → DS_IDLE immediately, HREADY=1 asynchronously.
- NPORT=1 is legal; all-zero PORT_EN makes every active transfer ERROR.

## Structure
- Shared package/include: FSM state encodings (2-bit DS_IDLE=0, DS_ERR1=1, DS_ERR2=2) and the default memory map localparams for the SoC (RAMCODE 0x0000_0000, RAMDATA 0x2000_0000, APB bridge 0x4000_0000, mask 0xFFFF_0000).
- One natural sub-module: ahblite_default_slave (FSM plus ready/resp generation). Decode and mux stay in the top.

## Test plan
- Reset: HRESETn=0 with HADDR=0x2000_0004 → HSEL=5'b00010, HREADY=1, HRESP=0, HRDATA=0.
- Mapped read: NONSEQ 0x4000_0010, slave 2 drives HRDATA_S=0xCAFE_0001 with 1 wait state → HREADY low 1 cycle, then HRDATA=0xCAFE_0001, HRESP=0.
- Unmapped NONSEQ 0x6000_0000 → HSEL=0, then HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then OKAY.
- Unmapped IDLE at 0x6000_0000 → zero-wait OKAY, FSM stays DS_IDLE.
- Back-to-back NONSEQ 0x6000_0000 then 0x0000_0100 → ERROR pair, then port 0 response muxed with no extra cycle.
- Overlap: PORT_BASE[1]=PORT_BASE[0]=0, PORT_EN=2'b11 → HSEL=2'b01; a disabled port at a matching address never selects.

Source files
------------

// File: rtl/ahblite_decode_mux_pkg.sv
// Shared definitions for the AHB-Lite decoder/mux: default-slave state
// encoding, SoC default memory map and a transfer-type helper.
package ahblite_decode_mux_pkg;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [31:0] MAP_RAMCODE_BASE = 32'h0000_0000;
    localparam logic [31:0] MAP_RAMDATA_BASE = 32'h2000_0000;
    localparam logic [31:0] MAP_APB_BASE     = 32'h4000_0000;
    localparam logic [31:0] MAP_REGION_MASK  = 32'hFFFF_0000;

    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahblite_decode_mux_default_slave.sv
// Default slave: answers active transfers to unmapped addresses with the
// two-cycle AHB ERROR response.
module ahblite_default_slave
    import ahblite_decode_mux_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic hready_i,
    input  logic err_req_i,
    output logic ready_o,
    output logic resp_o
);

    ds_state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= DS_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = DS_IDLE;
        case (state_q)
            DS_IDLE: state_d = (hready_i && err_req_i) ? DS_ERR1 : DS_IDLE;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = (hready_i && err_req_i) ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
    end

    always_comb begin
        ready_o = 1'b1;
        resp_o  = 1'b0;
        case (state_q)
            DS_ERR1: begin ready_o = 1'b0; resp_o = 1'b1; end
            DS_ERR2: begin ready_o = 1'b1; resp_o = 1'b1; end
            default: begin ready_o = 1'b1; resp_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/ahblite_decode_mux.sv
// AHB-Lite address decoder and slave-response multiplexer with an internal
// default slave for unmapped addresses.
module ahblite_decode_mux
    import ahblite_decode_mux_pkg::*;
#(
    parameter int                  NPORT     = 5,
    parameter logic [NPORT-1:0]    PORT_EN   = 5'b00111,
    parameter logic [NPORT*32-1:0] PORT_BASE = {32'h0, 32'h0, MAP_APB_BASE,
                                                MAP_RAMDATA_BASE, MAP_RAMCODE_BASE},
    parameter logic [NPORT*32-1:0] PORT_MASK = {32'h0, 32'h0, MAP_REGION_MASK,
                                                MAP_REGION_MASK, MAP_REGION_MASK}
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    output logic [NPORT-1:0]      HSEL,
    input  logic [NPORT-1:0]      HREADYOUT_S,
    input  logic [NPORT-1:0]      HRESP_S,
    input  logic [NPORT*32-1:0]   HRDATA_S,
    output logic                  HREADY,
    output logic                  HRESP,
    output logic [31:0]           HRDATA
);

    logic [NPORT-1:0] hit;
    logic [NPORT-1:0] hsel_dec;
    logic [NPORT-1:0] dsel_q, dsel_d;
    logic             err_req;
    logic             ds_ready, ds_resp;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NPORT; i++) begin
            hit[i] = PORT_EN[i] &&
                     ((HADDR & PORT_MASK[32*i +: 32]) ==
                      (PORT_BASE[32*i +: 32] & PORT_MASK[32*i +: 32]));
        end
    end

    // Scan downwards so the lowest-index hit is the last one written.
    always_comb begin
        hsel_dec = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hsel_dec    = '0;
                hsel_dec[i] = 1'b1;
            end
        end
    end

    assign HSEL    = hsel_dec;
    assign err_req = htrans_active(HTRANS) && (hsel_dec == '0);
    assign dsel_d  = HREADY ? hsel_dec : dsel_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) dsel_q <= '0;
        else          dsel_q <= dsel_d;
    end

    ahblite_default_slave u_default_slave (
        .clk_i     (HCLK),
        .rst_ni    (HRESETn),
        .hready_i  (HREADY),
        .err_req_i (err_req),
        .ready_o   (ds_ready),
        .resp_o    (ds_resp)
    );

    // dsel_q is one-hot or zero; zero hands the bus to the default slave.
    always_comb begin
        HREADY = ds_ready;
        HRESP  = ds_resp;
        HRDATA = 32'h0;
        for (int i = 0; i < NPORT; i++) begin
            if (dsel_q[i]) begin
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
                HRDATA = HRDATA_S[32*i +: 32];
            end
        end
    end

endmodule

// File: tb/tb_ahblite_decode_mux.sv
// Randomised bench for ahblite_decode_mux with a transaction-level model of
// the decoder, data-phase steering and the two-cycle ERROR response.
module tb_ahblite_decode_mux;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic [4:0]   HSEL;
    logic [4:0]   HREADYOUT_S;
    logic [4:0]   HRESP_S;
    logic [159:0] HRDATA_S;
    logic         HREADY, HRESP;
    logic [31:0]  HRDATA;

    logic [1:0]   HSEL2;
    logic         HREADY2, HRESP2;
    logic [31:0]  HRDATA2;

    int vectors = 0;
    int miscompares = 0;

    // Memory map as the bench understands it.
    logic [31:0] map_base [5] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h0, 32'h0};
    logic [31:0] map_mask [5] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0, 32'h0};
    bit          map_en   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Model state: which port owns the data phase (-1 = none) and how many
    // ERROR-response cycles remain.
    int m_dsel;
    int m_err;

    always #5 HCLK = ~HCLK;

    ahblite_decode_mux dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSEL(HSEL), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
        .HRDATA_S(HRDATA_S), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    ahblite_decode_mux #(
        .NPORT(2), .PORT_EN(2'b11), .PORT_BASE(64'h0),
        .PORT_MASK({32'hFFFF_0000, 32'hFFFF_0000})
    ) dut_ovl (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSEL(HSEL2), .HREADYOUT_S(2'b11), .HRESP_S(2'b00),
        .HRDATA_S(64'h0), .HREADY(HREADY2), .HRESP(HRESP2), .HRDATA(HRDATA2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 5; i++)
            if (map_en[i] && ((a & map_mask[i]) == (map_base[i] & map_mask[i])))
                return i;
        return -1;
    endfunction

    function automatic logic [4:0] exp_hsel(input logic [31:0] a);
        int k = decode(a);
        return (k < 0) ? 5'b0 : 5'(1 << k);
    endfunction

    task automatic model_reset();
        m_dsel = -1;
        m_err  = 0;
    endtask

    // Compare against the model mid-cycle, then advance the model on the edge.
    task automatic step();
        logic er, ep;
        logic [31:0] ed;
        int nd;
        #2;
        if (m_dsel >= 0) begin
            er = HREADYOUT_S[m_dsel];
            ep = HRESP_S[m_dsel];
            ed = HRDATA_S[m_dsel*32 +: 32];
        end else begin
            er = (m_err != 2);
            ep = (m_err != 0);
            ed = 32'h0;
        end
        chk("hsel",   32'(HSEL),   32'(exp_hsel(HADDR)));
        chk("hready", 32'(HREADY), 32'(er));
        chk("hresp",  32'(HRESP),  32'(ep));
        chk("hrdata", HRDATA,      ed);
        chk("hsel_overlap", 32'(HSEL2), (HADDR[31:16] == 16'h0) ? 32'd1 : 32'd0);
        @(posedge HCLK);
        if (er) begin
            nd     = decode(HADDR);
            m_dsel = nd;
            m_err  = (HTRANS[1] && nd < 0) ? 2 : 0;
        end else if (m_err == 2) begin
            m_err = 1;
        end
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t);
        HADDR  = a;
        HTRANS = t;
        #1;
    endtask

    task automatic rand_drive();
        logic [31:0] a;
        case ($urandom_range(0, 4))
            0: a = {16'h0000, 16'($urandom)};
            1: a = {16'h2000, 16'($urandom)};
            2: a = {16'h4000, 16'($urandom)};
            3: a = {16'h6000, 16'($urandom)};
            default: a = $urandom;
        endcase
        for (int i = 0; i < 5; i++) begin
            HREADYOUT_S[i] = ($urandom_range(0, 3) != 0);
            HRESP_S[i]     = ($urandom_range(0, 7) == 0);
            HRDATA_S[i*32 +: 32] = $urandom;
        end
        drive(a, 2'($urandom_range(0, 3)));
    endtask

    initial begin
        HRESETn     = 1'b0;
        HADDR       = 32'h2000_0004;
        HTRANS      = 2'b00;
        HREADYOUT_S = 5'b11111;
        HRESP_S     = 5'b00000;
        HRDATA_S    = '0;
        HRDATA_S[2*32 +: 32] = 32'hCAFE_0001;
        model_reset();
        #1;
        chk("rst_hsel",   32'(HSEL),   32'b00010);
        chk("rst_hready", 32'(HREADY), 32'd1);
        chk("rst_hresp",  32'(HRESP),  32'd0);
        chk("rst_hrdata", HRDATA,      32'h0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Mapped read to port 2 with one wait state.
        drive(32'h4000_0010, 2'b10);
        chk("rd_hsel", 32'(HSEL), 32'b00100);
        step();
        HREADYOUT_S[2] = 1'b0;
        drive(32'h6000_0000, 2'b10);
        chk("rd_wait_hready", 32'(HREADY), 32'd0);
        step();
        HREADYOUT_S[2] = 1'b1;
        drive(32'h6000_0000, 2'b10);
        chk("rd_hready", 32'(HREADY), 32'd1);
        chk("rd_hrdata", HRDATA, 32'hCAFE_0001);
        chk("rd_hresp",  32'(HRESP), 32'd0);
        chk("unm_hsel",  32'(HSEL), 32'd0);
        step();
        // ERROR pair for the unmapped NONSEQ, then port 0 with no extra cycle.
        drive(32'h0000_0100, 2'b10);
        chk("err1_hready", 32'(HREADY), 32'd0);
        chk("err1_hresp",  32'(HRESP),  32'd1);
        step();
        drive(32'h0000_0100, 2'b10);
        chk("err2_hready", 32'(HREADY), 32'd1);
        chk("err2_hresp",  32'(HRESP),  32'd1);
        chk("b2b_hsel",    32'(HSEL),   32'b00001);
        step();
        HRDATA_S[0 +: 32] = 32'h1234_5678;
        drive(32'h6000_0000, 2'b00);
        chk("p0_hready", 32'(HREADY), 32'd1);
        chk("p0_hresp",  32'(HRESP),  32'd0);
        chk("p0_hrdata", HRDATA,      32'h1234_5678);
        step();
        // Unmapped IDLE completes zero-wait OKAY.
        drive(32'h6000_0000, 2'b10);
        chk("idle_hready", 32'(HREADY), 32'd1);
        chk("idle_hresp",  32'(HRESP),  32'd0);
        chk("idle_hrdata", HRDATA,      32'h0);
        step();
        // Reset asserted in ERR1 forces HREADY high without a clock edge.
        drive(32'h6000_0000, 2'b00);
        chk("arst_pre_hready", 32'(HREADY), 32'd0);
        HRESETn = 1'b0;
        #1;
        chk("arst_hready", 32'(HREADY), 32'd1);
        chk("arst_hresp",  32'(HRESP),  32'd0);
        HRESETn = 1'b1;
        model_reset();
        step();

        for (int n = 0; n < 600; n++) begin
            rand_drive();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout at %0t: got running expected finished", $time);
        $fatal(1, "timeout");
    end

endmodule
